// File: rtl/onehot_decoder_buf.sv
// onehot_decoder_buf
// Expands an encoded index into a one-hot vector behind a 2-entry output
// buffer (main register + skid register). It also keeps a sticky mask of every
// delivered vector and a wrapping count of output handshakes.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_idx is the encoded index
//   out_valid/out_ready output handshake; out_onehot is the decoded vector
//   acc_clr           clears acc_mask and xfer_cnt
//   acc_mask          OR of delivered one-hot vectors since last clear/reset
//   xfer_cnt          output handshakes since last clear/reset (wraps)
module onehot_decoder_buf #(
    parameter  int IDX_W = 3,
    parameter  int CNT_W = 8,
    localparam int OUT_W = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    input  logic             acc_clr,
    output logic [OUT_W-1:0] acc_mask,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             main_valid;
    logic [OUT_W-1:0] main_data;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [OUT_W-1:0] dec;
    logic             in_hs;
    logic             out_hs;

    assign dec        = {{(OUT_W-1){1'b0}}, 1'b1} << in_idx;
    // skid_valid is a flop, so in_ready has no combinational input path
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_onehot = main_data;
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!main_valid) begin
            // skid is never occupied while main is empty
            if (in_hs) begin
                main_valid <= 1'b1;
                main_data  <= dec;
            end
        end else if (out_hs) begin
            if (skid_valid) begin
                main_data <= skid_data;
                if (in_hs) begin
                    skid_data <= dec;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (in_hs) begin
                main_data <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_hs) begin
            skid_valid <= 1'b1;
            skid_data  <= dec;
        end
    end

    // Clear takes effect first, then the same-cycle handshake contributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_mask <= '0;
            xfer_cnt <= '0;
        end else if (acc_clr) begin
            acc_mask <= out_hs ? main_data : '0;
            xfer_cnt <= out_hs ? CNT_W'(1) : '0;
        end else if (out_hs) begin
            acc_mask <= acc_mask | main_data;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_decoder_buf.sv
module tb_onehot_decoder_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_idx = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_onehot;
    logic       acc_clr = 1'b0;
    logic [7:0] acc_mask;
    logic [7:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of in-flight indices (capacity 2),
    // a mask of delivered indices and a plain handshake count.
    int   q[$];
    logic [7:0] m_mask;
    int   m_cnt;
    bit   m_fresh;   // no entry loaded since reset: out_onehot must read 0

    onehot_decoder_buf dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .acc_clr(acc_clr), .acc_mask(acc_mask), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2)});
        chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
        if (q.size() > 0)
            chk("out_onehot", {24'b0, out_onehot}, 32'd1 << q[0]);
        else if (m_fresh)
            chk("out_onehot_rst", {24'b0, out_onehot}, 32'd0);
        chk("acc_mask", {24'b0, acc_mask}, {24'b0, m_mask});
        chk("xfer_cnt", {24'b0, xfer_cnt}, m_cnt % 256);
    endtask

    // One clock: drive inputs, check outputs at the falling edge,
    // advance the model across the rising edge.
    task automatic step(input bit iv, input int idx, input bit ordy,
                        input bit clr, input bit r);
        bit ihs, ohs;
        in_valid  = iv;
        in_idx    = idx[2:0];
        out_ready = ordy;
        acc_clr   = clr;
        rst       = r;
        @(negedge clk);
        check_model();
        ihs = iv && (q.size() < 2);
        ohs = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_mask  = '0;
            m_cnt   = 0;
            m_fresh = 1'b1;
        end else begin
            if (clr) begin
                m_mask = '0;
                m_cnt  = 0;
            end
            if (ohs) begin
                m_mask = m_mask | (8'd1 << q[0]);
                m_cnt  = m_cnt + 1;
                void'(q.pop_front());
            end
            if (ihs) begin
                q.push_back(idx % 8);
                m_fresh = 1'b0;
            end
        end
    endtask

    initial begin
        int guard;
        q.delete();
        m_mask  = '0;
        m_cnt   = 0;
        m_fresh = 1'b1;

        // Reset and single index 5
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_onehot", {24'b0, out_onehot}, 32'h20);
        step(0, 0, 1, 0, 0);
        chk("single_mask", {24'b0, acc_mask}, 32'h20);
        chk("single_cnt", {24'b0, xfer_cnt}, 32'd1);

        // Back-to-back 0,3,7 after a clear
        step(0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 3, 1, 0, 0);
        step(1, 7, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("b2b_mask", {24'b0, acc_mask}, 32'h89);
        chk("b2b_cnt", {24'b0, xfer_cnt}, 32'd3);

        // Backpressure with 1,2,4
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        chk("bp_full", {31'b0, in_ready}, 32'd0);
        step(1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 4, 1, 0, 0);
        step(1, 4, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("bp_cnt", {24'b0, xfer_cnt}, 32'd6);

        // Fill the mask, then clear alone, then clear with idx 6 handshake
        for (int i = 0; i < 8; i++) step(1, i, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("mask_ff", {24'b0, acc_mask}, 32'hFF);
        step(0, 0, 1, 1, 0);
        chk("clr_mask", {24'b0, acc_mask}, 32'h00);
        chk("clr_cnt", {24'b0, xfer_cnt}, 32'd0);
        step(1, 6, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("clrhs_mask", {24'b0, acc_mask}, 32'h40);
        chk("clrhs_cnt", {24'b0, xfer_cnt}, 32'd1);

        // Counter wrap: 256 handshakes then one more
        step(0, 0, 0, 1, 0);
        guard = 0;
        while (m_cnt < 256 && guard < 1000) begin
            step(1, $urandom_range(0, 7), 1, 0, 0);
            guard++;
        end
        chk("wrap_reached", guard < 1000, 32'd1);
        chk("wrap0", {24'b0, xfer_cnt}, 32'd0);
        step(0, 0, 1, 0, 0);
        chk("wrap1", {24'b0, xfer_cnt}, 32'd1);

        // Reset with both entries buffered
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mask", {24'b0, acc_mask}, 32'd0);
        chk("rst_cnt", {24'b0, xfer_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("rst_nostale", {31'b0, out_valid}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
